seg_scan_sched: RTL and testbench

//  Dynamic-scan scheduler for the 6-digit common-anode 7-segment display.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_scan_sched_if.sv | 24 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg_scan_sched.sv | 143 ++++++++++++++
 tb/tb_seg_scan_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 6-digit 7-segment scan scheduler.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned DATA_W     = 4 * NUM_DIGITS;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value (entry 15 listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

endpackage

// File: rtl/seg_scan_sched_if.sv
// Update handshake and display outputs of the scan scheduler.
interface seg_scan_sched_if;
  import seg_pkg::*;

  logic                  en;
  logic                  upd_valid;
  logic [DATA_W-1:0]     upd_data;
  logic [NUM_DIGITS-1:0] upd_dp;
  logic                  upd_ready;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            seg;
  logic                  frame_done;

  modport master (
    output en, upd_valid, upd_data, upd_dp,
    input  upd_ready, sel, seg, frame_done
  );

  modport slave (
    input  en, upd_valid, upd_data, upd_dp,
    output upd_ready, sel, seg, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg_scan_sched.sv
// Dynamic-scan scheduler: one digit per slot with a dark gap at the slot start,
// new values staged and applied only at frame boundaries.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CNT = 50000,
  parameter int unsigned BLANK_CNT = 200,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seg_scan_sched_if.slave bus_io
);

  localparam int unsigned CntW = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CNT - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CNT - 1);
  localparam logic [IdxW-1:0] DigitLast = IdxW'(NUM_DIGITS - 1);

  state_e                state_q, state_d;
  logic [IdxW-1:0]       digit_q, digit_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  frame_end;

  logic                  stage_full_q;
  logic [DATA_W-1:0]     stage_data_q, shadow_data_q;
  logic [NUM_DIGITS-1:0] stage_dp_q, shadow_dp_q;
  logic                  accept, apply;

  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  frame_done_q;

  logic [3:0]            nibble;
  logic [6:0]            hex_seg;
  logic                  lz_blank;

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!bus_io.en) begin
      state_d = StIdle;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StBlank;
          digit_d = '0;
          cnt_d   = '0;
        end
        StBlank: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BlankLast) state_d = StShow;
        end
        StShow: begin
          if (cnt_q == DwellLast) begin
            cnt_d   = '0;
            state_d = StBlank;
            if (digit_q == DigitLast) begin
              digit_d   = '0;
              frame_end = 1'b1;
            end else begin
              digit_d = digit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Staging drains into the shadow only at a frame end, or at once while idle.
  assign accept           = bus_io.upd_valid && !stage_full_q;
  assign apply            = stage_full_q && (frame_end || (state_q == StIdle));
  assign bus_io.upd_ready = !stage_full_q;

  assign nibble = shadow_data_q[{digit_q, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

  // A digit is a leading zero when it and every digit above it are zero.
  assign lz_blank = LZ_BLANK && (digit_q != '0) &&
                    ((shadow_data_q >> {digit_q, 2'b00}) == '0);

  always_comb begin
    sel_d = '0;
    seg_d = SEG_OFF;
    if (bus_io.en && (state_q == StShow)) begin
      sel_d = NUM_DIGITS'(1) << digit_q;
      seg_d = {~shadow_dp_q[digit_q], lz_blank ? SEG_BLANK : hex_seg};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      digit_q      <= '0;
      cnt_q        <= '0;
      sel_q        <= '0;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_end;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_full_q  <= 1'b0;
      stage_data_q  <= '0;
      stage_dp_q    <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
    end else if (accept) begin
      stage_full_q <= 1'b1;
      stage_data_q <= bus_io.upd_data;
      stage_dp_q   <= bus_io.upd_dp;
    end else if (apply) begin
      stage_full_q  <= 1'b0;
      shadow_data_q <= stage_data_q;
      shadow_dp_q   <= stage_dp_q;
    end
  end

  assign bus_io.sel        = sel_q;
  assign bus_io.seg        = seg_q;
  assign bus_io.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Bench for seg_scan_sched: directed scenarios plus random traffic against a
// time-position model of the scan (frame position, staging, shadow).
module tb_seg_scan_sched;

  localparam int Dwell = 20;
  localparam int Blank = 4;
  localparam int Frame = 6 * Dwell;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_sched_if bus ();

  seg_scan_sched #(
    .DWELL_CNT (Dwell),
    .BLANK_CNT (Blank),
    .LZ_BLANK  (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: scan_t is the clock position inside the frame, -1 while not scanning.
  int          scan_t;
  logic [23:0] m_shadow, m_stage;
  logic [5:0]  m_shdp, m_stdp;
  bit          m_full;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic logic [7:0] model_seg(input logic [23:0] v, input logic [5:0] dp,
                                           input int d);
    logic [23:0] upper;
    logic [7:0]  s;
    upper = v >> (4 * d);
    s = hex_tab[upper[3:0]];
    if (d > 0 && upper == 24'h0) s = 8'hFF;
    s[7] = ~dp[d];
    return s;
  endfunction

  task automatic model_reset();
    scan_t   = -1;
    m_full   = 1'b0;
    m_shadow = '0;
    m_shdp   = '0;
    m_stage  = '0;
    m_stdp   = '0;
    exp_sel  = '0;
    exp_seg  = 8'hFF;
    exp_fd   = 1'b0;
  endtask

  task automatic model_step();
    bit idle, lit, fend, pre_full;
    int d;
    idle    = (scan_t < 0);
    d       = idle ? 0 : (scan_t / Dwell) % 6;
    lit     = bus.en && !idle && ((scan_t % Dwell) >= Blank);
    exp_sel = lit ? 6'(1 << d) : 6'h00;
    exp_seg = lit ? model_seg(m_shadow, m_shdp, d) : 8'hFF;
    fend    = bus.en && (scan_t == Frame - 1);
    exp_fd  = fend;
    pre_full = m_full;
    if (pre_full && (fend || idle)) begin
      m_shadow = m_stage;
      m_shdp   = m_stdp;
      m_full   = 1'b0;
    end else if (!pre_full && bus.upd_valid) begin
      m_stage = bus.upd_data;
      m_stdp  = bus.upd_dp;
      m_full  = 1'b1;
    end
    if (!bus.en) scan_t = -1;
    else scan_t = (scan_t + 1) % Frame;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (rst) begin
      check("sel", 32'(bus.sel), 32'(exp_sel));
      check("seg", 32'(bus.seg), 32'(exp_seg));
      check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
      check("upd_ready", 32'(bus.upd_ready), 32'(!m_full));
    end
    @(posedge clk);
    if (rst) model_step();
    cyc++;
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) cycle();
  endtask

  initial begin
    bus.en        = 1'b0;
    bus.upd_valid = 1'b0;
    bus.upd_data  = '0;
    bus.upd_dp    = '0;
    model_reset();

    #12;
    check("rst_sel", 32'(bus.sel), 32'h00);
    check("rst_seg", 32'(bus.seg), 32'hFF);
    check("rst_ready", 32'(bus.upd_ready), 32'h1);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    #11 rst = 1'b1;
    @(posedge clk);
    #1;

    bus.en = 1'b1;
    cyc = 0;
    run_to(5);   check("dark_gap", 32'(bus.sel), 32'h00);
    run_to(6);   check("d0_sel", 32'(bus.sel), 32'h01);
                 check("d0_seg", 32'(bus.seg), 32'hC0);
    run_to(26);  check("d1_sel", 32'(bus.sel), 32'h02);
                 check("d1_lz", 32'(bus.seg), 32'hFF);
    run_to(120); check("fd_early", 32'(bus.frame_done), 32'h0);
    run_to(121); check("fd_first", 32'(bus.frame_done), 32'h1);
    run_to(122); check("fd_pulse", 32'(bus.frame_done), 32'h0);
    run_to(126); check("f2_old", 32'(bus.seg), 32'hC0);

    run_to(150);
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h12345F;
    bus.upd_dp    = 6'b000100;
    cycle();
    bus.upd_valid = 1'b0;
    check("upd_taken", 32'(bus.upd_ready), 32'h0);
    run_to(240); check("upd_held", 32'(bus.upd_ready), 32'h0);
    run_to(241); check("fd_second", 32'(bus.frame_done), 32'h1);
                 check("ready_back", 32'(bus.upd_ready), 32'h1);
    run_to(246); check("new_d0_sel", 32'(bus.sel), 32'h01);
                 check("new_d0_seg", 32'(bus.seg), 32'h8E);
    run_to(266); check("new_d1_seg", 32'(bus.seg), 32'h92);
    run_to(286); check("new_d2_sel", 32'(bus.sel), 32'h04);
                 check("new_d2_dp", 32'(bus.seg), 32'h19);

    run_to(300);
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h000070;
    bus.upd_dp    = 6'b000000;
    cycle();
    bus.upd_valid = 1'b0;
    run_to(366); check("lz_d0", 32'(bus.seg), 32'hC0);
    run_to(386); check("lz_d1", 32'(bus.seg), 32'hF8);
    run_to(406); check("lz_d2", 32'(bus.seg), 32'hFF);
    run_to(466); check("lz_d5_sel", 32'(bus.sel), 32'h20);
                 check("lz_d5_seg", 32'(bus.seg), 32'hFF);

    run_to(470);
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h00ABCD;
    bus.upd_dp    = 6'b000000;
    cycle();
    bus.upd_data  = 24'h123456;
    bus.upd_dp    = 6'b100000;
    run_to(480); check("b2b_wait", 32'(bus.upd_ready), 32'h0);
    run_to(481); check("b2b_free", 32'(bus.upd_ready), 32'h1);
    run_to(482); check("b2b_take", 32'(bus.upd_ready), 32'h0);
    bus.upd_valid = 1'b0;
    run_to(486); check("b2b_first", 32'(bus.seg), 32'hA1);
    run_to(606); check("b2b_second", 32'(bus.seg), 32'h82);

    run_to(670); check("en_d3_sel", 32'(bus.sel), 32'h08);
                 check("en_d3_seg", 32'(bus.seg), 32'hB0);
    bus.en = 1'b0;
    cycle();     check("en_off_sel", 32'(bus.sel), 32'h00);
                 check("en_off_seg", 32'(bus.seg), 32'hFF);
    run_to(673);
    bus.en = 1'b1;
    run_to(678); check("restart_dark", 32'(bus.sel), 32'h00);
    run_to(679); check("restart_d0", 32'(bus.sel), 32'h01);
                 check("restart_seg", 32'(bus.seg), 32'h82);

    for (int i = 0; i < 2500; i++) begin
      bus.en        = ($urandom_range(0, 399) != 0);
      bus.upd_valid = ($urandom_range(0, 3) == 0);
      bus.upd_data  = 24'($urandom >> $urandom_range(8, 31));
      bus.upd_dp    = 6'($urandom);
      cycle();
    end

    bus.en        = 1'b1;
    bus.upd_valid = 1'b1;
    bus.upd_data  = 24'h888888;
    bus.upd_dp    = 6'h3F;
    cycle();
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 250; i++) cycle();
    for (int i = 0; i < 300 && bus.sel == 6'h00; i++) cycle();
    check("reach_show", 32'(bus.sel != 6'h00), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_sel", 32'(bus.sel), 32'h00);
    check("arst_seg", 32'(bus.seg), 32'hFF);
    check("arst_ready", 32'(bus.upd_ready), 32'h1);
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
    cyc = 0;
    run_to(6);   check("post_rst_d0", 32'(bus.sel), 32'h01);
                 check("post_rst_clr", 32'(bus.seg), 32'hC0);
    run_to(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
